// File: rtl/id_ex_hazard_reg_if.sv
// ID/EX boundary bundle: decoded control, operands and instruction fields
// coming out of ID, and their registered copies presented to EX.
interface id_ex_hazard_reg_if #(
    parameter int DATA_W = 32
);
    // ID-side (decoder / register file) signals
    logic [1:0]        id_PCSrc;
    logic [2:0]        id_Branch;
    logic              id_RegWrite;
    logic [1:0]        id_RegDst;
    logic              id_MemRead;
    logic              id_MemWrite;
    logic [1:0]        id_MemtoReg;
    logic              id_ALUSrc1;
    logic              id_ALUSrc2;
    logic              id_ExtOp;
    logic              id_LuOp;
    logic [3:0]        id_ALUOp;
    logic              id_Exception;
    logic [DATA_W-1:0] id_PC4;
    logic [DATA_W-1:0] id_RsData;
    logic [DATA_W-1:0] id_RtData;
    logic [4:0]        id_Rs;
    logic [4:0]        id_Rt;
    logic [4:0]        id_Rd;
    logic [4:0]        id_Shamt;
    logic [15:0]       id_Imm;

    // EX-side registered copies
    logic [1:0]        ex_PCSrc;
    logic [2:0]        ex_Branch;
    logic              ex_RegWrite;
    logic [1:0]        ex_RegDst;
    logic              ex_MemRead;
    logic              ex_MemWrite;
    logic [1:0]        ex_MemtoReg;
    logic              ex_ALUSrc1;
    logic              ex_ALUSrc2;
    logic              ex_ExtOp;
    logic              ex_LuOp;
    logic [3:0]        ex_ALUOp;
    logic              ex_Exception;
    logic [DATA_W-1:0] ex_PC4;
    logic [DATA_W-1:0] ex_RsData;
    logic [DATA_W-1:0] ex_RtData;
    logic [4:0]        ex_Rs;
    logic [4:0]        ex_Rt;
    logic [4:0]        ex_Rd;
    logic [4:0]        ex_Shamt;
    logic [15:0]       ex_Imm;
    logic              ex_valid;

    // ID stage drives the id_* fields and observes the EX entry
    modport master (
        output id_PCSrc, id_Branch, id_RegWrite, id_RegDst, id_MemRead, id_MemWrite,
               id_MemtoReg, id_ALUSrc1, id_ALUSrc2, id_ExtOp, id_LuOp, id_ALUOp,
               id_Exception, id_PC4, id_RsData, id_RtData, id_Rs, id_Rt, id_Rd,
               id_Shamt, id_Imm,
        input  ex_PCSrc, ex_Branch, ex_RegWrite, ex_RegDst, ex_MemRead, ex_MemWrite,
               ex_MemtoReg, ex_ALUSrc1, ex_ALUSrc2, ex_ExtOp, ex_LuOp, ex_ALUOp,
               ex_Exception, ex_PC4, ex_RsData, ex_RtData, ex_Rs, ex_Rt, ex_Rd,
               ex_Shamt, ex_Imm, ex_valid
    );

    // Pipeline register consumes id_* and produces the ex_* entry
    modport slave (
        input  id_PCSrc, id_Branch, id_RegWrite, id_RegDst, id_MemRead, id_MemWrite,
               id_MemtoReg, id_ALUSrc1, id_ALUSrc2, id_ExtOp, id_LuOp, id_ALUOp,
               id_Exception, id_PC4, id_RsData, id_RtData, id_Rs, id_Rt, id_Rd,
               id_Shamt, id_Imm,
        output ex_PCSrc, ex_Branch, ex_RegWrite, ex_RegDst, ex_MemRead, ex_MemWrite,
               ex_MemtoReg, ex_ALUSrc1, ex_ALUSrc2, ex_ExtOp, ex_LuOp, ex_ALUOp,
               ex_Exception, ex_PC4, ex_RsData, ex_RtData, ex_Rs, ex_Rt, ex_Rd,
               ex_Shamt, ex_Imm, ex_valid
    );
endinterface

// File: rtl/id_ex_hazard_reg.sv
// ID/EX pipeline register with load-use hazard detection.
// A load in EX whose destination (Rt) matches either source field of the
// instruction in ID forces a one-cycle stall and a bubble into EX. A flush
// from EX kills the entry being written and overrides the hazard. Bubble
// cycles are counted in a saturating counter.
module id_ex_hazard_reg #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    id_ex_hazard_reg_if.slave    bus,
    output logic                 stall,
    output logic [CNT_W-1:0]     bubble_cnt
);

    typedef struct packed {
        logic              valid;
        logic [1:0]        PCSrc;
        logic [2:0]        Branch;
        logic              RegWrite;
        logic [1:0]        RegDst;
        logic              MemRead;
        logic              MemWrite;
        logic [1:0]        MemtoReg;
        logic              ALUSrc1;
        logic              ALUSrc2;
        logic              ExtOp;
        logic              LuOp;
        logic [3:0]        ALUOp;
        logic              Exception;
        logic [DATA_W-1:0] PC4;
        logic [DATA_W-1:0] RsData;
        logic [DATA_W-1:0] RtData;
        logic [4:0]        Rs;
        logic [4:0]        Rt;
        logic [4:0]        Rd;
        logic [4:0]        Shamt;
        logic [15:0]       Imm;
    } exEntry_t;

    exEntry_t         exReg;
    exEntry_t         exNext;
    logic [CNT_W-1:0] bubbleCnt;
    logic [CNT_W-1:0] bubbleCntNext;
    logic             hazard;

    // Saturating increment: holds at all-ones instead of wrapping to zero
    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            return v;
        end else begin
            return v + CNT_W'(1);
        end
    endfunction

    // Load-use detection: conservative, both ID source fields are compared
    // regardless of instruction format; $0 never creates a dependency
    always_comb begin
        hazard = 1'b0;
        if (exReg.valid && exReg.MemRead && (exReg.Rt != 5'd0) &&
            ((exReg.Rt == bus.id_Rs) || (exReg.Rt == bus.id_Rt))) begin
            hazard = 1'b1;
        end else begin
            hazard = 1'b0;
        end
    end

    // Stall is same-cycle; a flush kills the ID instruction anyway, so no hold
    assign stall = hazard & ~flush & ~reset;

    // Next-entry selection, priority reset > flush > hazard > normal load
    always_comb begin
        exNext        = '0;
        bubbleCntNext = bubbleCnt;
        if (reset) begin
            exNext        = '0;
            bubbleCntNext = '0;
        end else if (flush) begin
            exNext        = '0;
        end else if (hazard) begin
            exNext        = '0;
            bubbleCntNext = satInc(bubbleCnt);
        end else begin
            exNext.valid     = 1'b1;
            exNext.PCSrc     = bus.id_PCSrc;
            exNext.Branch    = bus.id_Branch;
            exNext.RegWrite  = bus.id_RegWrite;
            exNext.RegDst    = bus.id_RegDst;
            exNext.MemRead   = bus.id_MemRead;
            exNext.MemWrite  = bus.id_MemWrite;
            exNext.MemtoReg  = bus.id_MemtoReg;
            exNext.ALUSrc1   = bus.id_ALUSrc1;
            exNext.ALUSrc2   = bus.id_ALUSrc2;
            exNext.ExtOp     = bus.id_ExtOp;
            exNext.LuOp      = bus.id_LuOp;
            exNext.ALUOp     = bus.id_ALUOp;
            exNext.Exception = bus.id_Exception;
            exNext.PC4       = bus.id_PC4;
            exNext.RsData    = bus.id_RsData;
            exNext.RtData    = bus.id_RtData;
            exNext.Rs        = bus.id_Rs;
            exNext.Rt        = bus.id_Rt;
            exNext.Rd        = bus.id_Rd;
            exNext.Shamt     = bus.id_Shamt;
            exNext.Imm       = bus.id_Imm;
        end
    end

    // Pipeline register and bubble counter; always advances, no backpressure
    always_ff @(posedge clk) begin
        exReg     <= exNext;
        bubbleCnt <= bubbleCntNext;
    end

    assign bus.ex_valid     = exReg.valid;
    assign bus.ex_PCSrc     = exReg.PCSrc;
    assign bus.ex_Branch    = exReg.Branch;
    assign bus.ex_RegWrite  = exReg.RegWrite;
    assign bus.ex_RegDst    = exReg.RegDst;
    assign bus.ex_MemRead   = exReg.MemRead;
    assign bus.ex_MemWrite  = exReg.MemWrite;
    assign bus.ex_MemtoReg  = exReg.MemtoReg;
    assign bus.ex_ALUSrc1   = exReg.ALUSrc1;
    assign bus.ex_ALUSrc2   = exReg.ALUSrc2;
    assign bus.ex_ExtOp     = exReg.ExtOp;
    assign bus.ex_LuOp      = exReg.LuOp;
    assign bus.ex_ALUOp     = exReg.ALUOp;
    assign bus.ex_Exception = exReg.Exception;
    assign bus.ex_PC4       = exReg.PC4;
    assign bus.ex_RsData    = exReg.RsData;
    assign bus.ex_RtData    = exReg.RtData;
    assign bus.ex_Rs        = exReg.Rs;
    assign bus.ex_Rt        = exReg.Rt;
    assign bus.ex_Rd        = exReg.Rd;
    assign bus.ex_Shamt     = exReg.Shamt;
    assign bus.ex_Imm       = exReg.Imm;
    assign bubble_cnt       = bubbleCnt;

endmodule

// File: tb/tb_id_ex_hazard_reg.sv
// Directed bench for id_ex_hazard_reg (4-bit bubble counter so saturation is reachable).
module tb_id_ex_hazard_reg;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;

    logic             clk;
    logic             reset;
    logic             flush;
    logic             stall;
    logic [CNT_W-1:0] bubble_cnt;

    int cmpCnt;
    int errCnt;

    id_ex_hazard_reg_if #(.DATA_W(DATA_W)) bus ();

    id_ex_hazard_reg #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .bus        (bus),
        .stall      (stall),
        .bubble_cnt (bubble_cnt)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        cmpCnt++;
        assert (obs === exp) else begin
            errCnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one decoded instruction in ID; other fields take fixed patterns
    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic memRead, input logic regWrite,
                         input logic [3:0] aluOp, input logic [15:0] imm);
        bus.id_PCSrc     = 2'b01;
        bus.id_Branch    = 3'b010;
        bus.id_RegWrite  = regWrite;
        bus.id_RegDst    = 2'b01;
        bus.id_MemRead   = memRead;
        bus.id_MemWrite  = 1'b0;
        bus.id_MemtoReg  = memRead ? 2'b01 : 2'b00;
        bus.id_ALUSrc1   = 1'b0;
        bus.id_ALUSrc2   = 1'b1;
        bus.id_ExtOp     = 1'b1;
        bus.id_LuOp      = 1'b0;
        bus.id_ALUOp     = aluOp;
        bus.id_Exception = 1'b0;
        bus.id_PC4       = 32'h0040_0004;
        bus.id_RsData    = 32'hAAAA_5555;
        bus.id_RtData    = 32'h1234_5678;
        bus.id_Rs        = rs;
        bus.id_Rt        = rt;
        bus.id_Rd        = rd;
        bus.id_Shamt     = 5'd3;
        bus.id_Imm       = imm;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        cmpCnt = 0;
        errCnt = 0;
        reset  = 1'b1;
        flush  = 1'b0;
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 4'b0000, 16'h0000);
        step();
        step();
        reset = 1'b0;
        check("init_valid", bus.ex_valid, 1'b0);
        check("init_cnt", bubble_cnt, 4'd0);

        // Normal load: fields pass through with one-cycle latency
        drive(5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 4'b0010, 16'h1234);
        step();
        check("norm_valid", bus.ex_valid, 1'b1);
        check("norm_regwrite", bus.ex_RegWrite, 1'b1);
        check("norm_aluop", bus.ex_ALUOp, 4'b0010);
        check("norm_imm", bus.ex_Imm, 16'h1234);
        check("norm_pc4", bus.ex_PC4, 32'h0040_0004);
        check("norm_rsdata", bus.ex_RsData, 32'hAAAA_5555);
        check("norm_rtdata", bus.ex_RtData, 32'h1234_5678);
        check("norm_rd", bus.ex_Rd, 5'd3);
        check("norm_branch", bus.ex_Branch, 3'b010);
        check("norm_shamt", bus.ex_Shamt, 5'd3);
        check("norm_stall", stall, 1'b0);

        // lw $8 then add $9,$8,$10: one stall, one bubble, add enters a cycle later
        drive(5'd29, 5'd8, 5'd0, 1'b1, 1'b1, 4'b0000, 16'h0010);
        step();
        check("lw_valid", bus.ex_valid, 1'b1);
        check("lw_memread", bus.ex_MemRead, 1'b1);
        drive(5'd8, 5'd10, 5'd9, 1'b0, 1'b1, 4'b0010, 16'h0000);
        #1;
        check("lu_stall", stall, 1'b1);
        step();
        check("lu_bubble_valid", bus.ex_valid, 1'b0);
        check("lu_bubble_regwrite", bus.ex_RegWrite, 1'b0);
        check("lu_bubble_memread", bus.ex_MemRead, 1'b0);
        check("lu_bubble_branch", bus.ex_Branch, 3'b000);
        check("lu_bubble_pcsrc", bus.ex_PCSrc, 2'b00);
        check("lu_cnt", bubble_cnt, 4'd1);
        check("lu_stall_drop", stall, 1'b0);
        step();
        check("lu_add_valid", bus.ex_valid, 1'b1);
        check("lu_add_rd", bus.ex_Rd, 5'd9);
        check("lu_add_rs", bus.ex_Rs, 5'd8);
        check("lu_add_cnt", bubble_cnt, 4'd1);

        // lw $0 then use of $0: no dependency
        drive(5'd29, 5'd0, 5'd0, 1'b1, 1'b1, 4'b0000, 16'h0020);
        step();
        drive(5'd0, 5'd0, 5'd11, 1'b0, 1'b1, 4'b0010, 16'h0000);
        #1;
        check("zero_stall", stall, 1'b0);
        step();
        check("zero_valid", bus.ex_valid, 1'b1);
        check("zero_rd", bus.ex_Rd, 5'd11);
        check("zero_cnt", bubble_cnt, 4'd1);

        // Load-use coinciding with flush: flush wins, no stall, no count
        drive(5'd29, 5'd8, 5'd0, 1'b1, 1'b1, 4'b0000, 16'h0030);
        step();
        drive(5'd8, 5'd10, 5'd9, 1'b0, 1'b1, 4'b0010, 16'h0000);
        flush = 1'b1;
        #1;
        check("flush_stall", stall, 1'b0);
        step();
        flush = 1'b0;
        check("flush_valid", bus.ex_valid, 1'b0);
        check("flush_regwrite", bus.ex_RegWrite, 1'b0);
        check("flush_cnt", bubble_cnt, 4'd1);

        // Reset held two cycles mid-stream with a pending load-use
        drive(5'd29, 5'd8, 5'd0, 1'b1, 1'b1, 4'b0000, 16'h0040);
        step();
        drive(5'd8, 5'd10, 5'd9, 1'b0, 1'b1, 4'b0010, 16'h0000);
        reset = 1'b1;
        #1;
        check("rst_stall", stall, 1'b0);
        step();
        step();
        check("rst_valid", bus.ex_valid, 1'b0);
        check("rst_cnt", bubble_cnt, 4'd0);
        check("rst_rt", bus.ex_Rt, 5'd0);
        check("rst_pc4", bus.ex_PC4, 32'd0);
        check("rst_regwrite", bus.ex_RegWrite, 1'b0);
        reset = 1'b0;

        // Repeated load-use pairs (Rt-field match) up to and past saturation
        for (int i = 0; i < 17; i++) begin
            drive(5'd29, 5'd8, 5'd0, 1'b1, 1'b1, 4'b0000, 16'h0050);
            step();
            drive(5'd3, 5'd8, 5'd12, 1'b0, 1'b1, 4'b0010, 16'h0000);
            #1;
            check("sat_stall", stall, 1'b1);
            step();
            if (i == 14) begin
                check("sat_cnt15", bubble_cnt, 4'hF);
            end else if (i == 0) begin
                check("sat_cnt1", bubble_cnt, 4'h1);
            end
        end
        check("sat_hold", bubble_cnt, 4'hF);
        check("sat_valid", bus.ex_valid, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCnt, errCnt);
        $finish;
    end

endmodule
